// File: rtl/sync_bus_pkg.sv
// Shared definitions for the round-robin shared-bus arbiter: FSM encoding
// and default sizing constants.
package sync_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_B   = 4;
  localparam int DEF_N   = 4;
  localparam int DEF_TMO = 16;

endpackage

// File: rtl/sync_bus_arbiter_if.sv
// Requester-side handshake bundle of the arbiter; master is the arbiter,
// slave is the requester/receiver side that drives req, din and ack.
interface sync_bus_arbiter_if
  import sync_bus_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int N = DEF_N
);
  logic [N-1:0]   req;
  logic [N*B-1:0] din;
  logic           ack;
  logic           rqst;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack_o;
  logic           err;

  modport master (
    input  req, din, ack,
    output rqst, gnt, ack_o, err
  );

  modport slave (
    output req, din, ack,
    input  rqst, gnt, ack_o, err
  );
endinterface

// File: rtl/sync_bus_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW-1:0] cand [N];

  // cand[k] is the requester examined k-th in priority order.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [PW:0] sum;
    assign sum      = {1'b0, ptr} + (PW+1)'(gi);
    assign cand[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
  end

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx   = cand[k];
        valid = 1'b1;
      end
    end
    grant = valid ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/sync_bus_arbiter.sv
// Round-robin arbiter that forwards one requester word at a time onto a
// shared tri-state bus, waiting for ack or timing out after TMO cycles.
module sync_bus_arbiter
  import sync_bus_pkg::*;
#(
  parameter int B   = DEF_B,
  parameter int N   = DEF_N,
  parameter int TMO = DEF_TMO
) (
  input  logic                clk,
  input  logic                rst,
  sync_bus_arbiter_if.master  bus,
  output logic [B-1:0]        BusData
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TMO);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] XFER = ST_XFER;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]    state_reg;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] win_reg;
  logic [N-1:0]  gnt_reg;
  logic [B-1:0]  data_reg;
  logic [CW-1:0] cnt_reg;
  logic          ok_reg;

  logic [N-1:0]  arb_grant;
  logic [PW-1:0] arb_idx;
  logic          arb_valid;

  rr_arbiter #(.N(N)) u_rr (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      ok_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            state_reg <= XFER;
            win_reg   <= arb_idx;
            gnt_reg   <= arb_grant;
            data_reg  <= bus.din[arb_idx*B +: B];
            cnt_reg   <= '0;
          end
        end
        XFER: begin
          if (bus.ack) begin
            ok_reg    <= 1'b1;
            state_reg <= DONE;
          end else if (cnt_reg == CW'(TMO - 1)) begin
            ok_reg    <= 1'b0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // The winner just served drops to lowest priority next round.
          state_reg <= IDLE;
          ptr_reg   <= (win_reg == PW'(N - 1)) ? '0 : win_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // All outputs decode from state so reset takes effect without a clock.
  assign bus.rqst  = (state_reg == XFER);
  assign bus.gnt   = (state_reg == XFER || state_reg == DONE) ? gnt_reg : '0;
  assign bus.ack_o = (state_reg == DONE && ok_reg) ? gnt_reg : '0;
  assign bus.err   = (state_reg == DONE) && !ok_reg;
  assign BusData   = (state_reg == XFER) ? data_reg : {B{1'bz}};
endmodule

// File: doc/sync_bus_arbiter.md
SYNC_BUS_ARBITER -- requirements
Module: sync_bus_arbiter

Interface
REQ-001 The block SHALL have parameter B, default 4, meaning bus data bitwidth.
REQ-002 The block SHALL have parameter N, default 4, meaning number of requesters (N >= 2).
REQ-003 The block SHALL have parameter TMO, default 16, meaning ack timeout in cycles (TMO >= 2).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; port clk is the clock.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port req  input  N  per-requester level request; bit i is requester i.
REQ-007 Port din  input  N*B  requester data; requester i occupies bits [i*B +: B].
REQ-008 Port ack  input  1  receiver acknowledge from the shared bus.
REQ-009 Port rqst  output  1  shared-bus request.
REQ-010 Port BusData  output  B  shared-bus data; all-z when not driving.
REQ-011 Port gnt  output  N  one-hot grant; all-zero when idle.
REQ-012 Port ack_o  output  N  one-cycle per-requester transfer-done pulse.
REQ-013 Port err  output  1  one-cycle timeout pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, XFER and DONE, all outputs registered or decoded from state.
REQ-015 In IDLE with req != 0, it SHALL choose the winner by round-robin, searching from index ptr upward with wrap, and enter XFER next cycle.
REQ-016 On that IDLE->XFER edge it SHALL latch the winner index and din slice; later changes to req/din SHALL NOT affect the transfer.
REQ-017 In XFER: rqst=1, BusData=latched data, gnt=one-hot winner; in IDLE and DONE: rqst=0, BusData='z.
REQ-018 gnt SHALL remain asserted through XFER and DONE.
REQ-019 In XFER, ack=1 sampled on a clock edge SHALL move to DONE with result OK.
REQ-020 In XFER, a cycle counter SHALL run from 0; if it reaches TMO-1 with ack=0, FSM SHALL move to DONE with result TIMEOUT.
REQ-021 The counter SHALL be ceil(log2(TMO)) bits wide and clear on every entry to XFER.
REQ-022 DONE SHALL last exactly one cycle, asserting ack_o[winner] if OK or err if TIMEOUT, never both; then IDLE.
REQ-023 On DONE->IDLE, ptr SHALL become (winner+1) mod N.
REQ-024 ack SHALL be ignored in IDLE and DONE.
REQ-025 Latency: req sampled in IDLE at edge t -> rqst=1 from t+1; ack=1 at the first XFER edge -> ack_o in the next cycle; minimum 3 cycles per word.
REQ-026 A requester holding req after its ack_o SHALL get lowest priority in the following IDLE arbitration.
REQ-027 A req withdrawn during XFER SHALL NOT abort the transfer.

Reset
REQ-028 While rst=1, outputs SHALL immediately be rqst=0, BusData='z, gnt=0, ack_o=0, err=0.
REQ-029 Reset SHALL set state=IDLE, ptr=0, counter=0 and clear latched data, including mid-XFER; no ack_o or err SHALL follow.

Structure
REQ-030 Package sync_bus_pkg SHALL hold the FSM state enum and the default B, N and TMO constants.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-032 N=4, B=4, ack tied 1: req=0001, din[3:0]=0xA -> rqst=1 and BusData=0xA for one cycle, ack_o=0001 the next cycle.
REQ-033 req=1111 held and ack tied 1 -> grants 0001, 0010, 0100, 1000, 0001 in order, every 3 cycles.
REQ-034 req=0100, ack held 0 -> rqst high 16 cycles, err pulses once, ack_o stays 0000, then BusData='z.
REQ-035 req=0010 with ack rising on the 5th XFER cycle -> BusData stable for 5 cycles, ack_o=0010 one cycle later.
REQ-036 rst pulsed during XFER -> rqst=0, BusData='z and gnt=0 immediately; next arbitration starts from ptr=0.
REQ-037 din changed and req dropped mid-XFER -> original data held on BusData until ack; ack_o still issued.
